// File: rtl/pim_pkg.sv
// Shared definitions for the PIM memory request sequencer: op codes, FSM states, width defaults.
package pim_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_ADD   = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_QUIET = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/pim_mem_controller.sv
// One-command-in-flight sequencer driving a four-phase Memory port (READ / WRITE / in-memory ADD).
// Optional strobe timeout is compiled in with `define PIM_TIMEOUT_EN.
module pim_mem_controller
    import pim_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
`ifdef PIM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready,
    output state_t            dbg_state
);

    // Command port: a command transfers on the edge where cmd_valid && cmd_ready are both high;
    // response port: a response transfers on the edge where rsp_valid && rsp_ready are both high,
    // and rsp_data/rsp_err hold steady until then.

    state_t            r_state;
    state_t            r_next;
    op_t               r_op;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] r_rdata;
    logic              r_cmd_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data_in;
    logic              r_mem_write;
    logic              r_mem_read;
    op_t               w_cmd_op;

`ifdef PIM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
`endif

    assign w_cmd_op = op_t'(cmd_op);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_next        <= ST_IDLE;
            r_op          <= OP_READ;
            r_operand     <= '0;
            r_rdata       <= '0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_err     <= 1'b0;
            r_mem_address <= '0;
            r_mem_data_in <= '0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
`ifdef PIM_TIMEOUT_EN
            r_tmo_cnt     <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef PIM_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    if (cmd_valid) begin
                        r_op          <= w_cmd_op;
                        r_operand     <= cmd_data;
                        r_rdata       <= '0;
                        r_mem_address <= cmd_addr;
                        r_cmd_ready   <= 1'b0;
                        if (w_cmd_op == OP_RSVD) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= '0;
                        end else if (mem_ready) begin
                            // Previous handshake not yet returned: wait it out before strobing.
                            r_state <= ST_QUIET;
                            r_next  <= (w_cmd_op == OP_WRITE) ? ST_WR : ST_RD;
                        end else if (w_cmd_op == OP_WRITE) begin
                            r_state       <= ST_WR;
                            r_mem_write   <= 1'b1;
                            r_mem_data_in <= cmd_data;
                        end else begin
                            r_state    <= ST_RD;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (mem_ready) begin
                        r_rdata    <= mem_data_out;
                        r_mem_read <= 1'b0;
                        r_state    <= ST_QUIET;
                        r_next     <= (r_op == OP_ADD) ? ST_WR : ST_RESP;
                    end
`ifdef PIM_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_mem_read  <= 1'b0;
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_WR: begin
                    if (mem_ready) begin
                        r_mem_write <= 1'b0;
                        r_state     <= ST_QUIET;
                        r_next      <= ST_RESP;
                    end
`ifdef PIM_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_mem_write <= 1'b0;
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ST_QUIET: begin
`ifdef PIM_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                    if (!mem_ready) begin
                        case (r_next)
                            ST_RD: begin
                                r_state    <= ST_RD;
                                r_mem_read <= 1'b1;
                            end
                            ST_WR: begin
                                // r_rdata is zero for WRITE, so this is the plain write data too.
                                r_state       <= ST_WR;
                                r_mem_write   <= 1'b1;
                                r_mem_data_in <= r_rdata + r_operand;
                            end
                            default: begin
                                r_state     <= ST_RESP;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b0;
                                r_rsp_data  <= (r_op == OP_WRITE) ? '0 : r_rdata;
                            end
                        endcase
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_mem_read  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_err     = r_rsp_err;
    assign mem_address = r_mem_address;
    assign mem_data_in = r_mem_data_in;
    assign mem_write   = r_mem_write;
    assign mem_read    = r_mem_read;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_pim_mem_controller.sv
// Directed bench for pim_mem_controller with a four-phase memory model behind the Memory port.
module tb_pim_mem_controller;
    import pim_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_ready;
    state_t            dbg_state;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              mem_stall;
    logic              saw_strobe;
    int                n_cmp = 0;
    int                n_err = 0;

    always #5 clock = ~clock;

    pim_mem_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready),
        .dbg_state    (dbg_state)
    );

    // Memory model: ready rises the cycle after a strobe is seen, falls the cycle after it drops.
    always @(posedge clock) begin
        if (reset || mem_stall) begin
            mem_ready <= 1'b0;
        end else if (mem_read || mem_write) begin
            if (!mem_ready) begin
                if (mem_write) mem[mem_address] <= mem_data_in;
                else           mem_data_out     <= mem[mem_address];
            end
            mem_ready <= 1'b1;
        end else begin
            mem_ready <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mem_read || mem_write) begin
            saw_strobe = 1'b1;
            chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
        end
    end

    // Issue one command, wait for its response, hold rsp_ready low for `hold` cycles, then accept.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data, input int hold,
                          input logic [DATA_W-1:0] exp_data, input logic exp_err, input int exp_lat);
        int guard;
        int lat;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        guard     = 0;
        while (!cmd_ready && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk({tag, "_accept"}, {31'b0, cmd_ready}, 32'd1);
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (lat < 300) begin
            @(negedge clock);
            lat++;
            if (lat == 1) chk({tag, "_busy"}, {31'b0, cmd_ready}, 32'd0);
            if (rsp_valid) break;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_data"}, rsp_data, exp_data);
        chk({tag, "_err"}, {31'b0, rsp_err}, {31'b0, exp_err});
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk({tag, "_hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            chk({tag, "_hold_data"}, rsp_data, exp_data);
        end
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        @(negedge clock);
        chk({tag, "_idle"}, {30'b0, cmd_ready, rsp_valid}, 32'd2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'b00;
        cmd_addr   = '0;
        cmd_data   = '0;
        rsp_ready  = 1'b0;
        mem_stall  = 1'b0;
        saw_strobe = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_mem_addr", {22'b0, mem_address}, 32'd0);
        chk("rst_mem_din", mem_data_in, 32'd0);
        reset = 1'b0;

        do_cmd("wr0", 2'b01, 10'h000, 32'hFA35_0123, 0, 32'h0000_0000, 1'b0, 5);
        chk("wr0_mem", mem[0], 32'hFA35_0123);
        do_cmd("rd0", 2'b00, 10'h000, 32'h0, 0, 32'hFA35_0123, 1'b0, 5);
        do_cmd("add0", 2'b10, 10'h000, 32'h0000_0001, 0, 32'hFA35_0123, 1'b0, 9);
        do_cmd("rd0b", 2'b00, 10'h000, 32'h0, 0, 32'hFA35_0124, 1'b0, 5);

        mem[10'h3FF] = 32'hFFFF_FFFF;
        do_cmd("add_wrap", 2'b10, 10'h3FF, 32'h0000_0001, 0, 32'hFFFF_FFFF, 1'b0, 9);
        do_cmd("rd_wrap", 2'b00, 10'h3FF, 32'h0, 3, 32'h0000_0000, 1'b0, 5);

        do_cmd("wr155", 2'b01, 10'h155, 32'hA5A5_A5A5, 0, 32'h0000_0000, 1'b0, 5);
        do_cmd("add155", 2'b10, 10'h155, 32'h5A5A_5A5B, 2, 32'hA5A5_A5A5, 1'b0, 9);
        do_cmd("rd155", 2'b00, 10'h155, 32'h0, 0, 32'h0000_0000, 1'b0, 5);
        chk("rd0_untouched", mem[0], 32'hFA35_0124);

        saw_strobe = 1'b0;
        do_cmd("rsvd", 2'b11, 10'h007, 32'h1234_5678, 1, 32'h0000_0000, 1'b1, 1);
        chk("rsvd_no_strobe", {31'b0, saw_strobe}, 32'd0);

        // Memory never answers; reset arrives while the write strobe is held.
        mem_stall = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_addr  = 10'h005;
        cmd_data  = 32'h1234_5678;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("stall_wr_strobe", {31'b0, mem_write}, 32'd1);
        chk("stall_wr_addr", {22'b0, mem_address}, 32'h005);
        chk("stall_wr_data", mem_data_in, 32'h1234_5678);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rstwr_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rstwr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rstwr_mem_addr", {22'b0, mem_address}, 32'd0);
        mem_stall = 1'b0;
        do_cmd("rd5", 2'b00, 10'h005, 32'h0, 0, 32'h0000_0000, 1'b0, 5);

`ifdef PIM_TIMEOUT_EN
        mem_stall = 1'b1;
        do_cmd("tmo_rd", 2'b00, 10'h000, 32'h0, 0, 32'h0000_0000, 1'b1, 65);
        chk("tmo_strobe_dropped", {30'b0, mem_read, mem_write}, 32'd0);
        mem_stall = 1'b0;
`endif

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
